// File: rtl/bird_motion_ctrl_if.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module   : bird_motion_ctrl_if
//  Brief    : Bundle between the motion engine and its environment: the raw
//             vertical sync and flap button coming in, and the bird
//             position, game state, score, frame tick and flap LED going out
//             to the renderer.
//  Revision : 1.0  initial release
// ============================================================================
interface bird_motion_ctrl_if;
  logic       iVS;
  logic       iBTN;
  logic [8:0] oBIRD_Y;
  logic [1:0] oSTATE;
  logic [7:0] oSCORE;
  logic       oFRAME_TICK;
  logic       oLED_NOTI;

  // Motion engine side
  modport master (
    input  iVS,
    input  iBTN,
    output oBIRD_Y,
    output oSTATE,
    output oSCORE,
    output oFRAME_TICK,
    output oLED_NOTI
  );

  // Environment / renderer side
  modport slave (
    output iVS,
    output iBTN,
    input  oBIRD_Y,
    input  oSTATE,
    input  oSCORE,
    input  oFRAME_TICK,
    input  oLED_NOTI
  );
endinterface
`default_nettype wire

// File: rtl/bird_motion_ctrl.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module   : bird_motion_ctrl
//  Brief    : Frame-locked game state and bird physics. One update per video
//             frame, triggered by the falling edge of the synchronised VS.
//             Optional macro FLAP_HOLD_EN: a held button auto-repeats flaps
//             once per frame (restart from DEAD still needs a fresh press).
//  Revision : 1.0  initial release
// ============================================================================
module bird_motion_ctrl #(
  parameter int SCREEN_H = 480,
  parameter int BIRD_H   = 24,
  parameter int Y_START  = 228,
  parameter int GRAVITY  = 1,
  parameter int FLAP_V   = 8,
  parameter int VMAX     = 10,
  parameter int SCORE_FR = 60
) (
  input  wire logic           iVGA_CLK,
  input  wire logic           iRST_n,
  bird_motion_ctrl_if.master  bus
);

  localparam int CNT_W = (SCORE_FR > 1) ? $clog2(SCORE_FR) : 1;

  localparam logic        [8:0]       Y_INIT    = 9'(Y_START);
  localparam logic        [8:0]       Y_FLOOR   = 9'(SCREEN_H - BIRD_H);
  localparam logic signed [10:0]      Y_FLOOR_S = 11'(SCREEN_H - BIRD_H);
  localparam logic signed [5:0]       VEL_FLAP  = 6'(-FLAP_V);
  localparam logic signed [5:0]       VEL_MAX   = 6'(VMAX);
  localparam logic signed [6:0]       VEL_MAX7  = 7'(VMAX);
  localparam logic signed [6:0]       GRAV7     = 7'(GRAVITY);
  localparam logic        [CNT_W-1:0] CNT_LAST  = CNT_W'(SCORE_FR - 1);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_PLAY = 2'd1,
    ST_DEAD = 2'd2
  } state_t;

  // Synchroniser and edge-history flops
  logic vs_s1_q, vs_s2_q, vs_prev_q;
  logic btn_s1_q, btn_s2_q, btn_prev_q;

  // Game state
  state_t             state_q,      state_d;
  logic [8:0]         y_q,          y_d;
  logic signed [5:0]  vel_q,        vel_d;
  logic [7:0]         score_q,      score_d;
  logic [CNT_W-1:0]   cnt_q,        cnt_d;
  logic               led_q,        led_d;
  logic               flap_pend_q,  flap_pend_d;
  logic               frame_tick_q, frame_tick_d;

  // Combinational helpers
  logic               btn_rise_w;
  logic               flap_edge_w;   // edge-only request (used for restart)
  logic               flap_play_w;   // request honoured in IDLE/PLAY
  logic signed [6:0]  vel_inc_w;
  logic signed [5:0]  vel_play_w;
  logic signed [10:0] nxt_w;

  // Two-flop synchronisers plus one history flop for edge detection
  always_ff @(posedge iVGA_CLK or negedge iRST_n) begin
    if (!iRST_n) begin
      vs_s1_q    <= 1'b1;
      vs_s2_q    <= 1'b1;
      vs_prev_q  <= 1'b1;
      btn_s1_q   <= 1'b0;
      btn_s2_q   <= 1'b0;
      btn_prev_q <= 1'b0;
    end else begin
      vs_s1_q    <= bus.iVS;
      vs_s2_q    <= vs_s1_q;
      vs_prev_q  <= vs_s2_q;
      btn_s1_q   <= bus.iBTN;
      btn_s2_q   <= btn_s1_q;
      btn_prev_q <= btn_s2_q;
    end
  end

  // Flap request, velocity and next-position arithmetic
  always_comb begin
    frame_tick_d = vs_prev_q & ~vs_s2_q;
    btn_rise_w   = btn_s2_q & ~btn_prev_q;
    // A rise landing in the tick cycle is folded in so it is not lost
    flap_edge_w  = flap_pend_q | btn_rise_w;
`ifdef FLAP_HOLD_EN
    flap_play_w  = flap_edge_w | btn_s2_q;
`else
    flap_play_w  = flap_edge_w;
`endif
    vel_inc_w    = {vel_q[5], vel_q} + GRAV7;
    if (flap_play_w) begin
      vel_play_w = VEL_FLAP;
    end else if (vel_inc_w > VEL_MAX7) begin
      vel_play_w = VEL_MAX;
    end else begin
      vel_play_w = vel_inc_w[5:0];
    end
    // Wide signed sum so both the ceiling and floor crossings are visible
    nxt_w = $signed({2'b00, y_q}) + $signed({{5{vel_play_w[5]}}, vel_play_w});
  end

  // Game FSM: everything changes only on the frame tick
  always_comb begin
    state_d     = state_q;
    y_d         = y_q;
    vel_d       = vel_q;
    score_d     = score_q;
    cnt_d       = cnt_q;
    led_d       = led_q;
    flap_pend_d = flap_edge_w;
    if (frame_tick_q) begin
      flap_pend_d = 1'b0;
      case (state_q)
        ST_IDLE: begin
          y_d     = Y_INIT;
          vel_d   = '0;
          score_d = '0;
          cnt_d   = '0;
          if (flap_play_w) begin
            state_d = ST_PLAY;
            vel_d   = VEL_FLAP;
            led_d   = ~led_q;
          end
        end
        ST_PLAY: begin
          vel_d = vel_play_w;
          if (flap_play_w) begin
            led_d = ~led_q;
          end
          if (nxt_w[10]) begin
            // Ceiling: stop dead at the top, game continues
            y_d   = '0;
            vel_d = '0;
          end else if (nxt_w >= Y_FLOOR_S) begin
            y_d     = Y_FLOOR;
            state_d = ST_DEAD;
          end else begin
            y_d = nxt_w[8:0];
          end
          if (cnt_q == CNT_LAST) begin
            cnt_d = '0;
            if (score_q != 8'hFF) begin
              score_d = score_q + 8'd1;
            end
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end
        ST_DEAD: begin
          // Restart ignores the hold feature and does not touch the LED
          if (flap_edge_w) begin
            state_d = ST_IDLE;
            y_d     = Y_INIT;
            vel_d   = '0;
            score_d = '0;
            cnt_d   = '0;
          end
        end
        default: begin
          state_d = ST_IDLE;
        end
      endcase
    end
  end

  // Game state registers
  always_ff @(posedge iVGA_CLK or negedge iRST_n) begin
    if (!iRST_n) begin
      state_q      <= ST_IDLE;
      y_q          <= Y_INIT;
      vel_q        <= '0;
      score_q      <= '0;
      cnt_q        <= '0;
      led_q        <= 1'b0;
      flap_pend_q  <= 1'b0;
      frame_tick_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      y_q          <= y_d;
      vel_q        <= vel_d;
      score_q      <= score_d;
      cnt_q        <= cnt_d;
      led_q        <= led_d;
      flap_pend_q  <= flap_pend_d;
      frame_tick_q <= frame_tick_d;
    end
  end

  assign bus.oBIRD_Y     = y_q;
  assign bus.oSTATE      = state_q;
  assign bus.oSCORE      = score_q;
  assign bus.oFRAME_TICK = frame_tick_q;
  assign bus.oLED_NOTI   = led_q;

endmodule
`default_nettype wire

// File: tb/tb_bird_motion_ctrl.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module   : tb_bird_motion_ctrl
//  Brief    : Directed, table-driven bench for bird_motion_ctrl, plus hand
//             sequences for asynchronous reset and tick/press coincidence.
//  Revision : 1.0  initial release
// ============================================================================
module tb_bird_motion_ctrl;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  bird_motion_ctrl_if bif ();

  bird_motion_ctrl dut (
    .iVGA_CLK (clk),
    .iRST_n   (rst_n),
    .bus      (bif)
  );

  // btn: 0 = low all frame, 1 = single pulse, 2 = high all frame,
  //      3 = two pulses in one frame
  typedef struct {
    int btn;
    int y;
    int st;
    int sc;
    bit chk_sc;
    bit led;
  } vec_t;

  vec_t vecs[$];
  int   n_cmp   = 0;
  int   n_bad   = 0;
  int   n_ticks = 0;

  always @(negedge clk) begin
    if (bif.oFRAME_TICK === 1'b1) n_ticks++;
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  function automatic void add(input int btn, input int y, input int st,
                              input int sc, input bit chk_sc, input bit led);
    vec_t v;
    v.btn = btn; v.y = y; v.st = st; v.sc = sc; v.chk_sc = chk_sc; v.led = led;
    vecs.push_back(v);
  endfunction

  function automatic void fill();
    bit L;
    int rise_a[15];
    int drop_a[10];
    rise_a = '{206, 203, 201, 200, 200, 201, 203, 206, 210, 215, 221, 228, 236, 245, 255};
    drop_a = '{1, 3, 6, 10, 15, 21, 28, 36, 45, 55};
    L = 1'b0;
    // Idle frames after reset
    for (int i = 0; i < 5; i++) add(0, 228, 0, 0, 1, L);
    // Start with a held press: one flap only
    L = ~L;
    add(2, 228, 1, 0, 1, L);
    add(2, 221, 1, 0, 1, L);
    add(2, 215, 1, 0, 1, L);
    add(2, 210, 1, 0, 1, L);
    // Coast up, over the top, down to terminal velocity
    for (int i = 0; i < 15; i++) add(0, rise_a[i], 1, 0, 1, L);
    for (int i = 1; i <= 20; i++) add(0, 255 + 10 * i, 1, 0, 1, L);
    // Floor crossing and frozen DEAD
    for (int i = 0; i < 3; i++) add(0, 456, 2, 0, 1, L);
    // Restart: LED untouched
    add(1, 228, 0, 0, 1, L);
    // Start again, then press every frame up to the ceiling
    L = ~L;
    add(1, 228, 1, 0, 1, L);
    for (int k = 1; k <= 29; k++) begin
      L = ~L;
      add((k == 1) ? 3 : 1, (k < 29) ? 228 - 8 * k : 0, 1, 0, 1, L);
    end
    // Hover at the ceiling
    for (int k = 0; k < 80; k++) begin
      L = ~L;
      add(1, 0, 1, 0, 0, L);
    end
    // Free fall to the floor
    for (int i = 0; i < 10; i++) add(0, drop_a[i], 1, 0, 0, L);
    for (int i = 1; i <= 40; i++) add(0, 55 + 10 * i, 1, 0, 0, L);
    add(0, 456, 2, 2, 1, L);
    add(0, 456, 2, 2, 1, L);
    add(0, 456, 2, 2, 1, L);
    // Restart clears score, LED untouched
    add(1, 228, 0, 0, 1, L);
    add(0, 228, 0, 0, 1, L);
  endfunction

  task automatic run_frame(input int btn, input string tag);
    int t0;
    t0 = n_ticks;
    bif.iBTN = (btn != 0);
    repeat (3) @(negedge clk);
    if (btn == 1 || btn == 3) bif.iBTN = 1'b0;
    repeat (3) @(negedge clk);
    if (btn == 3) bif.iBTN = 1'b1;
    repeat (3) @(negedge clk);
    if (btn == 3) bif.iBTN = 1'b0;
    repeat (3) @(negedge clk);
    bif.iVS = 1'b0;
    @(posedge clk);                  // edge k: VS first sampled low
    @(posedge clk); #1;
    chk({tag, "_tick_k1"}, bif.oFRAME_TICK, 1'b0);
    @(posedge clk); #1;
    chk({tag, "_tick_k2"}, bif.oFRAME_TICK, 1'b1);
    @(posedge clk); #1;
    chk({tag, "_tick_k3"}, bif.oFRAME_TICK, 1'b0);
    repeat (4) @(negedge clk);
    bif.iVS = 1'b1;
    repeat (4) @(negedge clk);
    chk({tag, "_ticks"}, n_ticks - t0, 1);
  endtask

  initial begin
    bif.iVS  = 1'b1;
    bif.iBTN = 1'b0;
    fill();

    // Reset values while held in reset and just after release
    repeat (3) @(negedge clk);
    chk("rst_y",     bif.oBIRD_Y,     228);
    chk("rst_st",    bif.oSTATE,      0);
    chk("rst_sc",    bif.oSCORE,      0);
    chk("rst_tick",  bif.oFRAME_TICK, 0);
    chk("rst_led",   bif.oLED_NOTI,   0);
    rst_n = 1'b1;
    repeat (3) @(negedge clk);
    chk("post_rst_y",  bif.oBIRD_Y, 228);
    chk("post_rst_st", bif.oSTATE,  0);

    // Table-driven frames
    foreach (vecs[i]) begin
      run_frame(vecs[i].btn, $sformatf("v%0d", i));
      chk($sformatf("v%0d_y", i),   bif.oBIRD_Y,   vecs[i].y);
      chk($sformatf("v%0d_st", i),  bif.oSTATE,    vecs[i].st);
      chk($sformatf("v%0d_led", i), bif.oLED_NOTI, vecs[i].led);
      if (vecs[i].chk_sc) chk($sformatf("v%0d_sc", i), bif.oSCORE, vecs[i].sc);
    end

    // Async reset mid-play with a flap pending
    run_frame(1, "ar0");
    run_frame(0, "ar1");
    run_frame(0, "ar2");
    chk("ar_pre_y",  bif.oBIRD_Y, 215);
    chk("ar_pre_st", bif.oSTATE,  1);
    @(negedge clk);
    bif.iBTN = 1'b1;
    repeat (4) @(negedge clk);
    bif.iBTN = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    chk("ar_y",   bif.oBIRD_Y,     228);
    chk("ar_st",  bif.oSTATE,      0);
    chk("ar_sc",  bif.oSCORE,      0);
    chk("ar_led", bif.oLED_NOTI,   0);
    chk("ar_tick",bif.oFRAME_TICK, 0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    run_frame(0, "ar3");
    chk("ar_discard_st",  bif.oSTATE,    0);
    chk("ar_discard_led", bif.oLED_NOTI, 0);

    // Press and VS fall sampled on the same edge: flap lands on that tick
    @(negedge clk);
    bif.iBTN = 1'b1;
    bif.iVS  = 1'b0;
    @(posedge clk);
    @(posedge clk); #1;
    chk("sim_tick_k1", bif.oFRAME_TICK, 0);
    @(posedge clk); #1;
    chk("sim_tick_k2", bif.oFRAME_TICK, 1);
    chk("sim_st_pre",  bif.oSTATE,      0);
    @(posedge clk); #1;
    chk("sim_st",  bif.oSTATE,    1);
    chk("sim_y",   bif.oBIRD_Y,   228);
    chk("sim_led", bif.oLED_NOTI, 1);
    repeat (3) @(negedge clk);
    bif.iVS  = 1'b1;
    bif.iBTN = 1'b0;
    repeat (6) @(negedge clk);
    run_frame(0, "sim1");
    chk("sim1_y", bif.oBIRD_Y, 221);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
`default_nettype wire
